// File: rtl/logic_test_pkg.sv
// Shared constants and helpers for the truth-table sweep logic.
// Holds the FSM state encoding and a constant-evaluable clog2.
// No logic of its own; imported by interface, timer and top.
package logic_test_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Smallest r such that 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle of sweep control, CUT stimulus/response and result signals.
// master = stimulus/CUT side, slave = the sweeper itself.
// No flow control: start is a level sampled only while idle.
interface truth_table_sweeper_if
  import logic_test_pkg::*;
#(
  parameter int N_IN = 3
);
  localparam int NP = 1 << N_IN;
  localparam int MW = clog2(NP + 1);

  logic            start;
  logic [NP-1:0]   expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [NP-1:0]   captured;
  logic [MW-1:0]   mismatch_cnt;
  logic            pass;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, captured, mismatch_cnt, pass
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, captured, mismatch_cnt, pass
  );

endinterface

// File: rtl/truth_table_sweeper_hold.sv
// Hold-cycle counter: counts 0..HOLD-1 while enabled, then restarts.
// o_tc is combinational on the count and marks the last hold cycle.
// Clear has priority over enable; no backpressure.
module hold_timer
  import logic_test_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = (HOLD > 1) ? clog2(HOLD) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(HOLD - 1));

  // Count hold cycles; wrap to zero at terminal count so it never overflows.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every N_IN-bit pattern onto a CUT for HOLD cycles, captures its output, compares to a table.
// Sweep takes 2**N_IN*HOLD cycles from the accepted start edge to the done pulse.
// start is only honoured while idle; requests during a sweep are dropped, not queued.
module truth_table_sweeper
  import logic_test_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int NP = 1 << N_IN;
  localparam int MW = clog2(NP + 1);

  logic [1:0]      r_state;
  logic [NP-1:0]   r_exp;
  logic [NP-1:0]   r_cap;
  logic [N_IN-1:0] r_pat;
  logic [MW-1:0]   r_mcnt;
  logic            r_pass;

  logic w_tc;
  logic w_mis;
  logic w_last;

  assign w_mis  = bus.dut_out ^ r_exp[r_pat];
  assign w_last = &r_pat;

  // The timer is held clear outside DRIVE so every sweep starts from hold=0.
  hold_timer #(.HOLD(HOLD)) u_hold (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (r_state != S_DRIVE),
    .i_en  (r_state == S_DRIVE),
    .o_tc  (w_tc)
  );

  // Sweep FSM: latch on start, sample on each terminal count, finish after the last pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_exp   <= '0;
      r_cap   <= '0;
      r_pat   <= '0;
      r_mcnt  <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_exp   <= bus.expected;
            r_cap   <= '0;
            r_mcnt  <= '0;
            r_pass  <= 1'b0;
            r_pat   <= '0;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (w_tc) begin
            r_cap[r_pat] <= bus.dut_out;
            if (w_mis) r_mcnt <= r_mcnt + MW'(1);
            if (w_last) begin
              // Fold in the final compare, which is not yet visible in r_mcnt.
              r_pass  <= (r_mcnt == '0) && !w_mis;
              r_state <= S_DONE;
            end else begin
              r_pat <= r_pat + N_IN'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_in       = r_pat;
  assign bus.busy         = (r_state == S_DRIVE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.captured     = r_cap;
  assign bus.mismatch_cnt = r_mcnt;
  assign bus.pass         = r_pass;

endmodule
